// File: rtl/uart_tx.sv
// uart_tx: transmit half of the SoC UART. Bytes enter a small FIFO through a
// valid/ready handshake and leave on tx as start, data (LSB first), optional
// parity and stop bits. Frames go out back-to-back while the FIFO is non-empty.
//
// Handshake: a byte is taken on a rising edge where tx_valid && tx_ready.
// tx_ready depends only on the pre-edge FIFO count, so a full FIFO refuses
// a byte even if the FSM pops on that same edge. The source must hold
// tx_data/tx_valid until it sees the transfer.
module uart_tx #(
    parameter int    CLK_FREQ   = 100_000_000,
    parameter int    BAUD_RATE  = 9600,
    parameter int    DATA_BIT   = 8,
    parameter int    STOP_BIT   = 1,
    parameter int    CHECK_BIT  = 0,
    parameter string CHECK_MODE = "EVEN",
    parameter int    FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    o_dbg_state
);
    localparam int              BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0]     BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
    localparam logic [2:0]      DATA_LAST    = 3'(DATA_BIT - 1);
    localparam logic [2:0]      STOP_LAST    = 3'(STOP_BIT - 1);
    localparam int              PW           = $clog2(FIFO_DEPTH);
    localparam int              CW           = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT     = CW'(FIFO_DEPTH);
    localparam logic [7:0]      DATA_MASK    = 8'((1 << DATA_BIT) - 1);
    localparam logic            ODD_PAR      = (CHECK_MODE == "ODD");

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Serializer state
    state_t        r_state;
    logic          r_tx;
    logic          r_busy;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [15:0]   r_baud_cnt;
    logic [2:0]    r_bit_cnt;

    // Next-state values from the FSM
    state_t        w_next_state;
    logic          w_next_tx;
    logic [7:0]    w_next_shift;
    logic          w_next_parity;
    logic [15:0]   w_next_baud;
    logic [2:0]    w_next_bit;
    logic          w_pop;

    logic          w_push;
    logic          w_bit_end;
    logic [7:0]    w_head;
    logic          w_head_par;

    assign tx_ready    = (r_count != FULL_CNT);
    assign w_push      = tx_valid && tx_ready;
    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];
    // Parity is taken from the byte as it is loaded, since shifting destroys it.
    assign w_head_par  = (^(w_head & DATA_MASK)) ^ ODD_PAR;

    assign tx          = r_tx;
    assign tx_busy     = r_busy;
    assign fifo_count  = r_count;
    assign o_dbg_state = r_state;

    // FIFO data array: written on every accepted push (no reset needed, count gates reads).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; push and pop on one edge leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state and datapath registers; tx and busy are registered so the line is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_tx       <= w_next_tx;
            r_busy     <= (w_next_state != S_IDLE);
            r_shift    <= w_next_shift;
            r_parity   <= w_next_parity;
            r_baud_cnt <= w_next_baud;
            r_bit_cnt  <= w_next_bit;
        end
    end

    // Next-state logic: frame sequencing, bit timing, and FIFO pops.
    always_comb begin
        w_next_state  = r_state;
        w_next_tx     = r_tx;
        w_next_shift  = r_shift;
        w_next_parity = r_parity;
        w_next_bit    = r_bit_cnt;
        w_pop         = 1'b0;
        w_next_baud   = (r_state == S_IDLE || w_bit_end) ? 16'd0 : r_baud_cnt + 16'd1;

        case (r_state)
            S_IDLE: begin
                w_next_tx = 1'b1;
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_next_shift  = w_head;
                    w_next_parity = w_head_par;
                    w_next_bit    = 3'd0;
                    w_next_state  = S_START;
                    w_next_tx     = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                    w_next_tx    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_next_bit = 3'd0;
                        if (CHECK_BIT != 0) begin
                            w_next_state = S_CHECK;
                            w_next_tx    = r_parity;
                        end else begin
                            w_next_state = S_STOP;
                            w_next_tx    = 1'b1;
                        end
                    end else begin
                        w_next_bit   = r_bit_cnt + 3'd1;
                        w_next_shift = r_shift >> 1;
                        w_next_tx    = r_shift[1];
                    end
                end
            end
            S_CHECK: begin
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                    w_next_tx    = 1'b1;
                    w_next_bit   = 3'd0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_next_bit = 3'd0;
                        if (r_count != '0) begin
                            w_pop         = 1'b1;
                            w_next_shift  = w_head;
                            w_next_parity = w_head_par;
                            w_next_state  = S_START;
                            w_next_tx     = 1'b0;
                        end else begin
                            w_next_state = S_IDLE;
                            w_next_tx    = 1'b1;
                        end
                    end else begin
                        w_next_bit = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_tx    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with different frame formats share one
// clock and reset. Frames are captured bit by bit off the line and compared
// with frames built from the byte values by a simple frame model.
module tb_uart_tx;
  localparam int BAUD = 10;
  localparam int DB   [4] = '{8, 8, 8, 7};
  localparam int SB   [4] = '{1, 1, 1, 2};
  localparam int CB   [4] = '{0, 1, 1, 0};
  localparam int ODDP [4] = '{0, 0, 1, 0};

  logic       clk;
  logic       rst;
  logic [7:0] tx_data    [4];
  logic       tx_valid   [4];
  logic       tx_ready   [4];
  logic       tx_line    [4];
  logic       tx_busy    [4];
  logic [2:0] fifo_count [4];
  logic [2:0] dbg_state  [4];

  int checks;
  int failures;

  // scoreboard / observation queues
  logic [7:0]  exp_q[$];
  logic [15:0] obs_q[$];
  logic [1:0]  flag_q[$];
  logic [2:0]  first_cnt_q[$];
  logic [2:0]  cnt_q[$];
  logic        rdy_q[$];
  logic [2:0]  mcnt_q[$];
  logic        mrdy_q[$];
  logic [7:0]  burst_data [8];

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
            .CHECK_BIT(0), .CHECK_MODE("EVEN"), .FIFO_DEPTH(4)) dut_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx_line[0]), .tx_busy(tx_busy[0]),
    .fifo_count(fifo_count[0]), .o_dbg_state(dbg_state[0]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
            .CHECK_BIT(1), .CHECK_MODE("EVEN"), .FIFO_DEPTH(4)) dut_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx_line[1]), .tx_busy(tx_busy[1]),
    .fifo_count(fifo_count[1]), .o_dbg_state(dbg_state[1]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
            .CHECK_BIT(1), .CHECK_MODE("ODD"), .FIFO_DEPTH(4)) dut_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx_line[2]), .tx_busy(tx_busy[2]),
    .fifo_count(fifo_count[2]), .o_dbg_state(dbg_state[2]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(7), .STOP_BIT(2),
            .CHECK_BIT(0), .CHECK_MODE("EVEN"), .FIFO_DEPTH(4)) dut_7n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx_line[3]), .tx_busy(tx_busy[3]),
    .fifo_count(fifo_count[3]), .o_dbg_state(dbg_state[3]));

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // frame model: bit list LSB first = start 0, data bits, optional parity, stop 1s
  function automatic logic [15:0] model_frame(input int k, input logic [7:0] b);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB[k]; i++) begin
      f[1 + i] = b[i];
      if (b[i]) ones++;
    end
    if (CB[k] != 0) f[1 + DB[k]] = ((ones % 2) == 1) ^ (ODDP[k] == 1);
    return f;
  endfunction

  function automatic int frame_len(input int k);
    return 1 + DB[k] + CB[k] + SB[k];
  endfunction

  // FIFO model for a burst of n cycles of tx_valid starting with an idle, empty
  // transmitter: accept while fewer than 4 held (pre-edge), the first pop happens
  // on the first edge the idle transmitter sees a non-empty FIFO.
  task automatic model_burst(input int n);
    int  occ;
    int  pre;
    bit  idle;
    bit  acc;
    bit  pop;
    occ = 0;
    idle = 1'b1;
    for (int i = 0; i < n; i++) begin
      pre = occ;
      acc = (pre < 4);
      pop = idle && (pre > 0);
      if (pop) idle = 1'b0;
      if (acc) exp_q.push_back(burst_data[i]);
      occ = pre + (acc ? 1 : 0) - (pop ? 1 : 0);
      mcnt_q.push_back(3'(occ));
      mrdy_q.push_back(occ < 4);
    end
  endtask

  // driver: holds tx_valid for n edges with burst_data, records count/ready after each edge
  task automatic drive_burst(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      tx_data[k]  = burst_data[i];
      tx_valid[k] = 1'b1;
      @(negedge clk);
      cnt_q.push_back(fifo_count[k]);
      rdy_q.push_back(tx_ready[k]);
    end
    tx_valid[k] = 1'b0;
  endtask

  // monitor: captures n consecutive frames starting on the next cycle
  task automatic run_frames(input int k, input int n);
    logic [15:0] obs;
    logic        stable;
    logic        busy_hi;
    for (int f = 0; f < n; f++) begin
      obs = '1;
      stable = 1'b1;
      busy_hi = 1'b1;
      for (int bi = 0; bi < frame_len(k); bi++) begin
        for (int c = 0; c < BAUD; c++) begin
          @(negedge clk);
          if (bi == 0 && c == 0) first_cnt_q.push_back(fifo_count[k]);
          if (c == 0) obs[bi] = tx_line[k];
          else if (tx_line[k] !== obs[bi]) stable = 1'b0;
          if (tx_busy[k] !== 1'b1) busy_hi = 1'b0;
        end
      end
      obs_q.push_back(obs);
      flag_q.push_back({stable, busy_hi});
    end
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); flag_q.delete(); first_cnt_q.delete();
    cnt_q.delete(); rdy_q.delete(); mcnt_q.delete(); mrdy_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_line[k] !== 1'b1) begin failures++; $display("FAIL reset_tx inst%0d got=%b exp=1", k, tx_line[k]); end
      checks++;
      if (tx_busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy inst%0d got=%b exp=0", k, tx_busy[k]); end
      checks++;
      if (tx_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_ready inst%0d got=%b exp=1", k, tx_ready[k]); end
      checks++;
      if (fifo_count[k] !== 3'd0) begin failures++; $display("FAIL reset_count inst%0d got=%0d exp=0", k, fifo_count[k]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // push one byte on instance k and compare the frame, latency and frame length
  task automatic test_single(input string name, input int k, input logic [7:0] b, input int par_exp);
    logic [15:0] o;
    logic [15:0] e;
    logic [1:0]  fl;
    clear_queues();
    burst_data[0] = b;
    fork
      drive_burst(k, 1);
      begin @(negedge clk); run_frames(k, 1); end
    join
    model_burst(1);
    checks++;
    if (cnt_q[0] !== mcnt_q[0]) begin failures++; $display("FAIL %s count_after_push got=%0d exp=%0d", name, cnt_q[0], mcnt_q[0]); end
    checks++;
    if (first_cnt_q[0] !== 3'd0) begin failures++; $display("FAIL %s count_after_pop got=%0d exp=0", name, first_cnt_q[0]); end
    o = obs_q.pop_front();
    e = model_frame(k, exp_q.pop_front());
    fl = flag_q.pop_front();
    checks++;
    if (o !== e) begin failures++; $display("FAIL %s frame got=%h exp=%h", name, o, e); end
    checks++;
    if (fl !== 2'b11) begin failures++; $display("FAIL %s stable_busy got=%b exp=11", name, fl); end
    if (par_exp >= 0) begin
      checks++;
      if (o[1 + DB[k]] !== 1'(par_exp)) begin
        failures++; $display("FAIL %s parity_bit got=%b exp=%0d", name, o[1 + DB[k]], par_exp);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_busy[k] !== 1'b0) begin failures++; $display("FAIL %s busy_after_frame got=%b exp=0", name, tx_busy[k]); end
    checks++;
    if (tx_line[k] !== 1'b1) begin failures++; $display("FAIL %s idle_line got=%b exp=1", name, tx_line[k]); end
  endtask

  // n valid cycles then nf back-to-back frames compared against the scoreboard
  task automatic test_burst(input string name, input int k, input int n, input int nf);
    logic [15:0] o;
    logic [15:0] e;
    logic [1:0]  fl;
    clear_queues();
    fork
      drive_burst(k, n);
      begin @(negedge clk); run_frames(k, nf); end
    join
    model_burst(n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cnt_q[i] !== mcnt_q[i]) begin failures++; $display("FAIL %s count_edge%0d got=%0d exp=%0d", name, i, cnt_q[i], mcnt_q[i]); end
      checks++;
      if (rdy_q[i] !== mrdy_q[i]) begin failures++; $display("FAIL %s ready_edge%0d got=%b exp=%b", name, i, rdy_q[i], mrdy_q[i]); end
    end
    checks++;
    if (exp_q.size() != nf) begin failures++; $display("FAIL %s accepted got=%0d exp=%0d", name, exp_q.size(), nf); end
    for (int f = 0; f < nf; f++) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? model_frame(k, exp_q.pop_front()) : 16'hxxxx;
      fl = flag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s frame%0d got=%h exp=%h", name, f, o, e); end
      checks++;
      if (fl !== 2'b11) begin failures++; $display("FAIL %s frame%0d stable_busy got=%b exp=11", name, f, fl); end
    end
    @(negedge clk);
    checks++;
    if (tx_busy[k] !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b exp=0", name, tx_busy[k]); end
  endtask

  task automatic test_back_to_back();
    burst_data[0] = 8'h01;
    burst_data[1] = 8'h02;
    burst_data[2] = 8'h03;
    test_burst("back_to_back", 0, 3, 3);
    // fifo occupancy at the start of frames 1..3: 1, then 1 and 0 after each boundary pop
    checks++;
    if (first_cnt_q[0] !== 3'd1) begin failures++; $display("FAIL b2b_count_f0 got=%0d exp=1", first_cnt_q[0]); end
    checks++;
    if (first_cnt_q[1] !== 3'd1) begin failures++; $display("FAIL b2b_count_f1 got=%0d exp=1", first_cnt_q[1]); end
    checks++;
    if (first_cnt_q[2] !== 3'd0) begin failures++; $display("FAIL b2b_count_f2 got=%0d exp=0", first_cnt_q[2]); end
  endtask

  task automatic test_hold_full();
    for (int i = 0; i < 8; i++) burst_data[i] = 8'($urandom_range(0, 255));
    test_burst("hold_full", 0, 8, 5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) burst_data[i] = 8'($urandom_range(0, 255));
      test_burst("random", k, 3, 3);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] e;
    logic        line_ok;
    logic        busy_ok;
    clear_queues();
    burst_data[0] = 8'($urandom_range(0, 255)) & 8'hF7;
    burst_data[1] = 8'($urandom_range(0, 255));
    burst_data[2] = 8'($urandom_range(0, 255));
    drive_burst(0, 3);
    // now after edge N+2; data bit 3 covers edges N+41..N+50
    repeat (41) @(negedge clk);
    e = model_frame(0, burst_data[0]);
    checks++;
    if (tx_line[0] !== e[4]) begin failures++; $display("FAIL rst_mid pre_reset_bit3 got=%b exp=%b", tx_line[0], e[4]); end
    checks++;
    if (fifo_count[0] !== 3'd2) begin failures++; $display("FAIL rst_mid queued got=%0d exp=2", fifo_count[0]); end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_line[0] !== 1'b1) begin failures++; $display("FAIL rst_mid tx got=%b exp=1", tx_line[0]); end
    checks++;
    if (fifo_count[0] !== 3'd0) begin failures++; $display("FAIL rst_mid count got=%0d exp=0", fifo_count[0]); end
    checks++;
    if (tx_busy[0] !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", tx_busy[0]); end
    checks++;
    if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL rst_mid ready got=%b exp=1", tx_ready[0]); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    line_ok = 1'b1;
    busy_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_line[0] !== 1'b1) line_ok = 1'b0;
      if (tx_busy[0] !== 1'b0 || fifo_count[0] !== 3'd0) busy_ok = 1'b0;
    end
    checks++;
    if (line_ok !== 1'b1) begin failures++; $display("FAIL rst_mid line_after got=%b exp=1", line_ok); end
    checks++;
    if (busy_ok !== 1'b1) begin failures++; $display("FAIL rst_mid idle_after got=%b exp=1", busy_ok); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single("single_8n1_a5", 0, 8'hA5, -1);
    test_single("parity_even_07", 1, 8'h07, 1);
    test_single("parity_odd_07", 2, 8'h07, 0);
    test_single("short_7n2_ff", 3, 8'hFF, -1);
    test_single("short_7n2_7e", 3, 8'h7E, -1);
    test_back_to_back();
    test_hold_full();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Parameterized UART transmitter, the transmit half of the SoC's UART peripheral; its frame parameters match the receive path. Bytes are accepted over a valid/ready handshake into a small internal FIFO. Each byte is serialized onto `tx` as start bit, DATA_BIT data bits LSB first, an optional parity bit, and STOP_BIT stop bits. Frames go out back-to-back while the FIFO is non-empty.

## Interface
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 9600: line rate. BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE (integer division), must be ≤ 65535.
- DATA_BIT, 8: data bits per frame, legal 5..8.
- STOP_BIT, 1: stop bits, legal 1 or 2.
- CHECK_BIT, 0: 1 = append parity bit, 0 = none.
- CHECK_MODE, "EVEN": "EVEN" or "ODD" parity.
- FIFO_DEPTH, 4: byte entries, power of 2, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  8  byte to send; only bits [DATA_BIT-1:0] are transmitted.
- tx_valid  in  1  write request.
- tx_ready  out  1  FIFO not full. Combinational from the FIFO count only.
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  state != IDLE, registered.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

## Operation
- Push: a push happens on a clock edge when tx_valid && tx_ready. With tx_ready=0, tx_valid is ignored and the data is dropped; the source must hold it.
- Pop: a pop happens only from the FSM, when it loads the shift register.
- Simultaneous push and pop: fifo_count is unchanged. Push acceptance depends on the pre-edge count, so a full FIFO rejects a push even when a pop occurs on the same edge.
- Pointers wrap modulo FIFO_DEPTH.
- Baud counter: 16-bit `baud_cnt` counts 0..BAUD_CNT_MAX-1 within each bit. Every bit lasts exactly BAUD_CNT_MAX cycles.
- Bit counter: `bit_cnt` counts data bits and stop bits.
- FSM states:
  - IDLE: tx=1. If fifo_count≠0, pop into the shift register, go to START, tx←0.
  - START: at baud_cnt end, go to DATA, tx←shift[0].
  - DATA: at each bit end, shift right and drive the next bit. After bit DATA_BIT-1, go to CHECK if CHECK_BIT=1, else go to STOP with tx←1.
  - CHECK: tx = parity over the DATA_BIT data bits. EVEN: ^data. ODD: ~^data. At the end of the bit, go to STOP with tx←1.
  - STOP: tx=1 for STOP_BIT bit periods. At the end of the last stop bit:
    - if fifo_count≠0, pop and go to START with tx←0, leaving no idle gap;
    - otherwise go to IDLE.
- Frame length: (1+DATA_BIT+CHECK_BIT+STOP_BIT)·BAUD_CNT_MAX cycles.
- Reset values: tx=1, tx_busy=0, tx_ready=1, fifo_count=0, FSM in IDLE, counters 0, FIFO empty.
- Reset mid-frame: the frame is aborted immediately (asynchronously). tx returns to 1 and all queued bytes are discarded.

## Timing
- Latency: with the FIFO empty and the FSM in IDLE, a push at edge N gives fifo_count=1 after N. At edge N+1 the pop occurs, the FSM enters START, tx=0 and tx_busy=1. fifo_count returns to 0 after N+1.
- tx and tx_busy change only on clock edges; tx is glitch-free.
- tx_busy falls on the edge where the last stop bit ends with the FIFO empty. For a single frame pushed at edge N, that is edge N+1+frame length.
- fifo_count and tx_ready update on the same edge as the push or pop.

## Test plan
Test parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BAUD_CNT_MAX=10), FIFO_DEPTH=4.
- 8N1, push 0xA5 at edge N → tx=0 over cycles N+1..N+10. Then 1,0,1,0,0,1,0,1, each held 10 cycles. Then 1 for 10 cycles. tx_busy high over edges N+1..N+100, low at N+101.
- CHECK_BIT=1, push 0x07 → parity bit 1 with "EVEN", 0 with "ODD". Frame is 110 cycles.
- Push 3 bytes 0x01, 0x02, 0x03 on consecutive edges → three frames with no idle cycle between them (300 cycles). tx_busy stays high throughout. fifo_count sequence 1,1,2 then decrements at each frame boundary.
- Hold tx_valid high for 8 cycles from edge N → exactly 5 bytes accepted (edges N..N+4). tx_ready=0 from after N+4. fifo_count=4. All 5 bytes are later transmitted in order.
- Assert rst during data bit 3 of a frame, with 2 bytes queued → tx=1 immediately, fifo_count=0, tx_busy=0. After release with no pushes, tx stays 1.
- DATA_BIT=7, STOP_BIT=2, push 0xFF → 7 data bits of 1 (bit 7 not sent), stop level held 20 cycles. Frame is 100 cycles.
